// File: rtl/lbm_mouse_event_decoder.sv
// lbm_mouse_event_decoder
// Gathers the separately written HPS mouse PIO words (x, y, left, right, direction)
// and waits until they have all stayed unchanged for STABLE_CYCLES cycles. It then
// clamps the coordinates to the LBM grid and emits one paint/erase/move event per
// settled change on a valid/ready stream.
// Optional feature: `define EVT_DROP_CNT_EN adds a saturating counter of snapshots
// that settled while an earlier event was still waiting for the consumer.
module lbm_mouse_event_decoder #(
   parameter int GRID_W        = 320,
   parameter int GRID_H        = 240,
   parameter int XW            = 9,
   parameter int YW            = 8,
   parameter int STABLE_CYCLES = 16
) (
   input  logic          clk_clk,
   input  logic          reset_reset_n,
   input  logic [26:0]   pio_x_coord,
   input  logic [26:0]   pio_y_coord,
   input  logic [31:0]   pio_left_click,
   input  logic [31:0]   pio_right_click,
   input  logic [31:0]   pio_direction,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [XW-1:0] evt_x,
   output logic [YW-1:0] evt_y,
   output logic [1:0]    evt_op,
   output logic [1:0]    evt_dir,
   output logic [15:0]   evt_drop_cnt
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_RLD = CW'(STABLE_CYCLES - 1);
   localparam logic [26:0]   GW      = 27'(GRID_W);
   localparam logic [26:0]   GH      = 27'(GRID_H);

   // Only the bits that carry meaning take part in the stability compare.
   typedef struct packed {
      logic [26:0] x;
      logic [26:0] y;
      logic        left;
      logic        right;
      logic [1:0]  dir;
   } snap_t;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT} state_t;

   state_t          state_q;
   snap_t           snap_q, last_q, em_q, in_snap;
   logic [CW-1:0]   cnt_q;
   logic            pend_q;
   logic            evt_valid_q;
   logic [XW-1:0]   evt_x_q;
   logic [YW-1:0]   evt_y_q;
   logic [1:0]      evt_op_q, evt_dir_q;
   logic            chg, accept;
   logic [XW-1:0]   x_cl;
   logic [YW-1:0]   y_cl;
   logic [1:0]      op_d;
   logic            unused_bits;

   assign unused_bits = ^{pio_left_click[31:1], pio_right_click[31:1], pio_direction[31:2]};

   assign in_snap = '{x: pio_x_coord, y: pio_y_coord, left: pio_left_click[0],
                      right: pio_right_click[0], dir: pio_direction[1:0]};
   assign chg     = (in_snap != snap_q);
   assign accept  = evt_valid_q && evt_ready;

   // Full-width compare so huge raw values clamp rather than wrap; paint wins over erase.
   assign x_cl = (snap_q.x >= GW) ? XW'(GRID_W - 1) : snap_q.x[XW-1:0];
   assign y_cl = (snap_q.y >= GH) ? YW'(GRID_H - 1) : snap_q.y[YW-1:0];
   assign op_d = snap_q.left ? 2'b01 : (snap_q.right ? 2'b10 : 2'b00);

   // Settle/emit FSM; evt_* only change when an event is registered.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= S_IDLE;
         snap_q      <= '0;
         last_q      <= '0;
         em_q        <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_x_q     <= '0;
         evt_y_q     <= '0;
         evt_op_q    <= '0;
         evt_dir_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (chg) begin
                  snap_q  <= in_snap;
                  cnt_q   <= CNT_RLD;
                  state_q <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (chg) begin
                  snap_q <= in_snap;
                  cnt_q  <= CNT_RLD;
               end else if (cnt_q == '0) begin
                  if (snap_q == last_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     evt_x_q     <= x_cl;
                     evt_y_q     <= y_cl;
                     evt_op_q    <= op_d;
                     evt_dir_q   <= snap_q.dir;
                     em_q        <= snap_q;
                     evt_valid_q <= 1'b1;
                     pend_q      <= 1'b0;
                     state_q     <= S_EMIT;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_EMIT: begin
               if (accept) begin
                  evt_valid_q <= 1'b0;
                  last_q      <= em_q;
                  pend_q      <= 1'b0;
                  if (chg) begin
                     snap_q  <= in_snap;
                     cnt_q   <= CNT_RLD;
                     state_q <= S_SETTLE;
                  end else if (snap_q != em_q) begin
                     // A newer state arrived while waiting; finish (or reuse) its settle.
                     cnt_q   <= (pend_q && cnt_q != '0) ? cnt_q - 1'b1 : '0;
                     state_q <= S_SETTLE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (chg) begin
                  snap_q <= in_snap;
                  cnt_q  <= CNT_RLD;
                  pend_q <= 1'b1;
               end else if (pend_q) begin
                  if (cnt_q == '0) pend_q <= 1'b0;
                  else             cnt_q  <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_x     = evt_x_q;
   assign evt_y     = evt_y_q;
   assign evt_op    = evt_op_q;
   assign evt_dir   = evt_dir_q;

`ifdef EVT_DROP_CNT_EN
   logic [15:0] drop_q;
   logic        settle_emit;

   assign settle_emit = (state_q == S_EMIT) && !accept && !chg && pend_q && (cnt_q == '0);

   // Count states that settle while the previous event is still stalled.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)                          drop_q <= '0;
      else if (settle_emit && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
   end

   assign evt_drop_cnt = drop_q;
`else
   assign evt_drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_lbm_mouse_event_decoder.sv
// Bench for lbm_mouse_event_decoder: directed scenarios followed by a randomized
// phase checked cycle by cycle against a stability-run reference model.
module tb_lbm_mouse_event_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [26:0] x, y;
   logic [31:0] lc, rc, dc;
   logic        rdy;
   logic        evt_valid;
   logic [8:0]  evt_x;
   logic [7:0]  evt_y;
   logic [1:0]  evt_op, evt_dir;
   logic [15:0] evt_drop_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lbm_mouse_event_decoder dut (
      .clk_clk         (clk),
      .reset_reset_n   (rst_n),
      .pio_x_coord     (x),
      .pio_y_coord     (y),
      .pio_left_click  (lc),
      .pio_right_click (rc),
      .pio_direction   (dc),
      .evt_valid       (evt_valid),
      .evt_ready       (rdy),
      .evt_x           (evt_x),
      .evt_y           (evt_y),
      .evt_op          (evt_op),
      .evt_dir         (evt_dir),
      .evt_drop_cnt    (evt_drop_cnt)
   );

`ifdef EVT_DROP_CNT_EN
   localparam logic [15:0] EXP_DROP = 16'd2;
`else
   localparam logic [15:0] EXP_DROP = 16'd0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tick until evt_valid is seen or the budget runs out; n = ticks taken.
   task automatic wait_evt(input string tag, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!evt_valid && n < budget);
      chk(tag, {63'b0, evt_valid}, 64'd1);
   endtask

   // With ready held high every pulse is one tick long, so this counts events.
   task automatic quiet(input string tag, input int ncyc);
      int ev = 0;
      for (int i = 0; i < ncyc; i++) begin
         tick();
         if (evt_valid) ev++;
      end
      chk(tag, 64'(ev), 64'd0);
   endtask

   function automatic logic [57:0] red(input logic [26:0] fx, input logic [26:0] fy,
                                       input logic fl, input logic fr, input logic [1:0] fd);
      return {fx, fy, fl, fr, fd};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [26:0] xs [6];
      logic [26:0] ys [5];
      logic [57:0] prev, last, cur;
      int          run;
      logic [26:0] xv, yv;
      logic        lv, rv;
      logic [1:0]  dv;
      logic        exp_v;

      xs = '{27'd0, 27'd5, 27'd319, 27'd320, 27'd1000, 27'h7FFFFFF};
      ys = '{27'd0, 27'd20, 27'd239, 27'd240, 27'd500};

      // T1: reset state, then one event 17 cycles after the change
      rst_n = 1'b0; x = '0; y = '0; lc = '0; rc = '0; dc = '0; rdy = 1'b1;
      repeat (3) tick();
      chk("rst_valid", {63'b0, evt_valid}, 64'd0);
      chk("rst_fields", {evt_x, evt_y, evt_op, evt_dir}, 64'd0);
      chk("rst_drop", 64'(evt_drop_cnt), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      x = 27'd10; y = 27'd20; lc = 32'd1;
      wait_evt("t1_evt", 40, n);
      chk("t1_latency", 64'(n), 64'd17);
      chk("t1_x", 64'(evt_x), 64'd10);
      chk("t1_y", 64'(evt_y), 64'd20);
      chk("t1_op", 64'(evt_op), 64'd1);
      chk("t1_dir", 64'(evt_dir), 64'd0);
      quiet("t1_single", 30);

      // T2: short glitch that returns to the emitted value
      x = 27'd5;
      wait_evt("t2_evt", 40, n);
      chk("t2_x", 64'(evt_x), 64'd5);
      x = 27'd6;
      repeat (4) tick();
      x = 27'd5;
      quiet("t2_glitch", 40);

      // T3: clamping, with a full-width raw value
      x = 27'd1000; y = 27'd500;
      wait_evt("t3_evt", 40, n);
      chk("t3_x", 64'(evt_x), 64'd319);
      chk("t3_y", 64'(evt_y), 64'd239);
      x = 27'h7FFFFFF;
      wait_evt("t3_evt_max", 40, n);
      chk("t3_x_max", 64'(evt_x), 64'd319);
      chk("t3_y_max", 64'(evt_y), 64'd239);

      // T4: paint wins, direction reduced, upper bits ignored
      lc = 32'd1; rc = 32'd1; dc = 32'hFFFF_FFFE;
      wait_evt("t4_evt", 40, n);
      chk("t4_op", 64'(evt_op), 64'd1);
      chk("t4_dir", 64'(evt_dir), 64'd2);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         lc = $urandom | 32'd1;
         rc = $urandom | 32'd1;
         dc = ($urandom & ~32'd3) | 32'd2;
         tick();
         if (evt_valid) n++;
      end
      chk("t4_noise", 64'(n), 64'd0);

      // T5: back-pressure while x steps 1,2,3
      rdy = 1'b0; lc = 32'd1; rc = 32'd1; dc = 32'd2;
      for (int i = 0; i < 100; i++) begin
         x = (i < 20) ? 27'd1 : ((i < 40) ? 27'd2 : 27'd3);
         tick();
         if (i >= 16) begin
            chk("t5_hold_valid", {63'b0, evt_valid}, 64'd1);
            chk("t5_hold_x", 64'(evt_x), 64'd1);
         end
      end
      chk("t5_drop", 64'(evt_drop_cnt), 64'(EXP_DROP));
      rdy = 1'b1;
      wait_evt("t5_evt", 40, n);
      chk("t5_x", 64'(evt_x), 64'd3);
      quiet("t5_single", 30);

      // T6: asynchronous reset while an event is stalled
      rdy = 1'b0; x = 27'd77;
      wait_evt("t6_evt", 40, n);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", {63'b0, evt_valid}, 64'd0);
      chk("t6_fields", {evt_x, evt_y, evt_op, evt_dir}, 64'd0);
      chk("t6_drop", 64'(evt_drop_cnt), 64'd0);
      x = '0; y = '0; lc = '0; rc = '0; dc = '0; rdy = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      quiet("t6_idle", 30);

      // Randomized: an event appears exactly when a value completes a run of 17
      // consecutive samples and differs from the last emitted value.
      prev = '0; last = '0; run = 100;
      for (int seg = 0; seg < 150; seg++) begin
         int len;
         xv = xs[$urandom_range(0, 5)];
         yv = ys[$urandom_range(0, 4)];
         lv = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1));
         dv = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 30);
         for (int k = 0; k < len; k++) begin
            x  = xv; y = yv;
            lc = ($urandom & ~32'd1) | 32'(lv);
            rc = ($urandom & ~32'd1) | 32'(rv);
            dc = ($urandom & ~32'd3) | 32'(dv);
            cur = red(xv, yv, lv, rv, dv);
            tick();
            if (cur == prev) run++;
            else run = 1;
            prev  = cur;
            exp_v = (run == 17) && (cur != last);
            if (exp_v) last = cur;
            chk("rnd_valid", {63'b0, evt_valid}, {63'b0, exp_v});
            if (exp_v) begin
               chk("rnd_x", 64'(evt_x), (xv >= 27'd320) ? 64'd319 : 64'(xv));
               chk("rnd_y", 64'(evt_y), (yv >= 27'd240) ? 64'd239 : 64'(yv));
               chk("rnd_op", 64'(evt_op), lv ? 64'd1 : (rv ? 64'd2 : 64'd0));
               chk("rnd_dir", 64'(evt_dir), 64'(dv));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
